// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DATA_MEM between the core MEM stage
// (fixed priority) and a DMA/debug master. A starvation counter forces one
// DMA grant after MAX_WAIT consecutive denied cycles, stalling the core for
// that cycle. DATA_MEM has a 1-cycle read latency; a one-deep read-owner
// register routes the returning word to the DMA read channel.
//
// Optional feature: define DMEM_ARB_RANGE_CHK_EN to reject DMA requests
// outside [WIN_BASE, WIN_BASE+WIN_SIZE). Rejected requests are accepted
// (dma_ready=1) but never reach DATA_MEM; dma_err pulses one cycle later.
module dmem_arbiter #(
    parameter int          ADDR_W   = 10,
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] WIN_BASE = 32'h0000_0800,
    parameter logic [31:0] WIN_SIZE = 32'h0000_0800
) (
    input  logic              clk,
    input  logic              rst_n,
    // core MEM stage
    input  logic              cpu_req,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    // DMA / debug master
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic [3:0]        dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              dma_err,
    // DATA_MEM port
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    localparam logic [0:0] ST_CPU   = 1'b0;
    localparam logic [0:0] ST_FORCE = 1'b1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [0:0] state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic       cpu_gnt, dma_gnt, dma_issue, dma_in_win;
    logic       rd_owner_q;
    mreq_t      cpu_r, dma_r, sel_r;

    assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_r = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

`ifdef DMEM_ARB_RANGE_CHK_EN
    logic err_q;

    // Window test done in 33 bits so a window ending at 4 GiB cannot wrap.
    always_comb begin
        dma_in_win = ({1'b0, dma_addr} >= {1'b0, WIN_BASE}) &&
                     ({1'b0, dma_addr} <  ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
    end

    // Accepted-but-rejected DMA requests report an error one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= dma_gnt & ~dma_in_win;
    end

    assign dma_err = err_q;
`else
    logic unused_win;

    assign dma_in_win = 1'b1;
    assign dma_err    = 1'b0;
    assign unused_win = ^{WIN_BASE, WIN_SIZE};
`endif

    // Grant decision: core wins in ST_CPU, DMA wins in ST_FORCE. Nothing is
    // granted while reset is held so the RAM port stays quiet.
    always_comb begin
        cpu_gnt   = 1'b0;
        dma_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (rst_n) begin
            case (state)
                ST_FORCE: begin
                    // A master that withdrew leaves the core unstalled.
                    dma_gnt   = dma_valid;
                    cpu_gnt   = cpu_req & ~dma_valid;
                    cpu_stall = cpu_req & dma_valid;
                end
                default: begin
                    cpu_gnt = cpu_req;
                    dma_gnt = ~cpu_req & dma_valid;
                end
            endcase
        end
    end

    assign dma_ready = dma_gnt;
    assign dma_issue = dma_gnt & dma_in_win;

    // Memory port mux of the granted master; write enables only on a real issue.
    always_comb begin
        sel_r     = cpu_gnt ? cpu_r : dma_r;
        mem_en    = cpu_gnt | dma_issue;
        mem_we    = mem_en ? sel_r.we : 4'h0;
        mem_addr  = sel_r.addr[ADDR_W+1:2];
        mem_wdata = sel_r.wdata;
    end

    // Starvation counter: counts consecutive denied DMA cycles, saturating;
    // reaching the limit forces the next cycle to the DMA.
    always_comb begin
        if (dma_valid && !dma_gnt)
            wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 4'd1;
        else
            wait_nxt = 4'd0;
        state_nxt = (wait_nxt == WAIT_MAX) ? ST_FORCE : ST_CPU;
    end

    // Arbitration state and starvation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CPU;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Read owner: marks the cycle whose RAM output belongs to a DMA read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_owner_q <= 1'b0;
        else        rd_owner_q <= dma_issue & (dma_we == 4'h0);
    end

    assign dma_rvalid = rd_owner_q;
    assign dma_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{sel_r.addr[31:ADDR_W+2], sel_r.addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset checks, a vector table of single-cycle grant
// cases, directed multi-cycle sequences, then constrained-random traffic
// scored against a rule-level reference model with a shadow memory.
module tb_dmem_arbiter;

    localparam int          ADDR_W = 10;
    localparam int          MAXW   = 4;
    localparam logic [31:0] WB     = 32'h0000_0800;
    localparam logic [31:0] WS     = 32'h0000_0800;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, dma_valid;
    logic [3:0]        cpu_we, dma_we;
    logic [31:0]       cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0]       cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic              cpu_stall, dma_ready, dma_rvalid, dma_err, mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              clr_ram;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAXW), .WIN_BASE(WB), .WIN_SIZE(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // DATA_MEM environment model: 1-cycle read latency, byte enables.
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (clr_ram) begin
            for (int i = 0; i < (1<<ADDR_W); i++) ram[i] <= 32'h0;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_valid = 1'b0; dma_we = 4'h0; dma_addr = 32'h0; dma_wdata = 32'h0;
    endtask

    function automatic logic [9:0] wd(input logic [31:0] a);
        return a[11:2];
    endfunction

    function automatic bit in_window(input logic [31:0] a);
`ifdef DMEM_ARB_RANGE_CHK_EN
        longint unsigned x, lo, hi;
        x = longint'(a); lo = longint'(WB); hi = longint'(WB) + longint'(WS);
        return (x >= lo) && (x < hi);
`else
        return (a == a);
`endif
    endfunction

    typedef struct {
        logic        cr;  logic [3:0] cwe; logic [31:0] ca; logic [31:0] cd;
        logic        dv;  logic [3:0] dwe; logic [31:0] da; logic [31:0] dd;
        logic        e_en; logic [3:0] e_we; logic [9:0] e_addr; logic [31:0] e_wd;
        logic        e_stall; logic e_rdy;
    } vec_t;

    vec_t vt [6];

    // reference model state for random phase
    logic [31:0] shadow [0:1023];
    int          streak;
    bit          p_dma_rd, p_cpu_rd, p_err, last_rdy, last_stall;
    logic [31:0] p_dma_data, p_cpu_data;

    initial begin
        int cnt;
        vt[0] = '{1'b0, 4'h0, 32'h0, 32'h0,              1'b0, 4'h0, 32'h0,   32'h0,
                  1'b0, 4'h0, 10'h000, 32'h0,            1'b0, 1'b0};
        vt[1] = '{1'b1, 4'h3, 32'h40, 32'h1122_3344,     1'b0, 4'h0, 32'h0,   32'h0,
                  1'b1, 4'h3, 10'h010, 32'h1122_3344,    1'b0, 1'b0};
        vt[2] = '{1'b1, 4'h0, 32'hFFFF_F07C, 32'h0,      1'b0, 4'h0, 32'h0,   32'h0,
                  1'b1, 4'h0, 10'h01F, 32'h0,            1'b0, 1'b0};
        vt[3] = '{1'b0, 4'h0, 32'h0, 32'h0,              1'b1, 4'hF, 32'h900, 32'hA5A5_A5A5,
                  1'b1, 4'hF, 10'h240, 32'hA5A5_A5A5,    1'b0, 1'b1};
        vt[4] = '{1'b1, 4'h1, 32'h8, 32'h55,             1'b1, 4'h0, 32'h900, 32'h0,
                  1'b1, 4'h1, 10'h002, 32'h55,           1'b0, 1'b0};
        vt[5] = '{1'b0, 4'h0, 32'h0, 32'h0,              1'b1, 4'h0, 32'h907, 32'h0,
                  1'b1, 4'h0, 10'h241, 32'h0,            1'b0, 1'b1};

        // reset with both masters requesting: port must stay quiet
        idle();
        cpu_req = 1'b1; dma_valid = 1'b1;
        rst_n = 1'b0; clr_ram = 1'b1;
        #3;
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst cpu_stall", 32'(cpu_stall), 32'h0);
        chk("rst dma_ready", 32'(dma_ready), 32'h0);
        chk("rst dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("rst dma_err", 32'(dma_err), 32'h0);
        idle();
        tick(); tick();
        rst_n = 1'b1; clr_ram = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mid();
            chk("idle mem_en", 32'(mem_en), 32'h0);
            chk("idle cpu_stall", 32'(cpu_stall), 32'h0);
            chk("idle dma_ready", 32'(dma_ready), 32'h0);
            chk("idle dma_rvalid", 32'(dma_rvalid), 32'h0);
            tick();
        end

        // single-cycle grant table, each followed by an idle cycle
        for (int i = 0; i < 6; i++) begin
            cpu_req = vt[i].cr; cpu_we = vt[i].cwe; cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
            dma_valid = vt[i].dv; dma_we = vt[i].dwe; dma_addr = vt[i].da; dma_wdata = vt[i].dd;
            mid();
            chk($sformatf("vec%0d mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
            if (vt[i].e_en) chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
            if (vt[i].e_en && vt[i].e_we != 4'h0)
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vt[i].e_wd);
            chk($sformatf("vec%0d cpu_stall", i), 32'(cpu_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d dma_ready", i), 32'(dma_ready), 32'(vt[i].e_rdy));
            tick();
            idle();
            mid();
            tick();
        end

        // CPU store then load of 0x10
        cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        mid();
        chk("st mem_addr", 32'(mem_addr), 32'h4);
        chk("st mem_we", 32'(mem_we), 32'hF);
        tick();
        cpu_we = 4'h0;
        mid();
        chk("ld mem_en", 32'(mem_en), 32'h1);
        chk("ld mem_we", 32'(mem_we), 32'h0);
        tick();
        idle();
        mid();
        chk("ld cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // DMA-only read of 0x10
        dma_valid = 1'b1; dma_addr = 32'h10;
        mid();
        chk("dmard ready", 32'(dma_ready), 32'h1);
        chk("dmard mem_addr", 32'(mem_addr), 32'h4);
        tick();
        idle();
        mid();
        chk("dmard rvalid", 32'(dma_rvalid), 32'h1);
        chk("dmard rdata", dma_rdata, 32'hDEAD_BEEF);
        tick();
        mid();
        chk("dmard rvalid pulse", 32'(dma_rvalid), 32'h0);
        tick();

        // starvation: 4 denials, forced grant with stall, then CPU resumes
        cpu_req = 1'b1; cpu_addr = 32'h20;
        dma_valid = 1'b1; dma_addr = 32'h10;
        for (int k = 1; k <= MAXW; k++) begin
            mid();
            chk($sformatf("starve%0d ready", k), 32'(dma_ready), 32'h0);
            chk($sformatf("starve%0d stall", k), 32'(cpu_stall), 32'h0);
            tick();
        end
        mid();
        chk("force ready", 32'(dma_ready), 32'h1);
        chk("force stall", 32'(cpu_stall), 32'h1);
        chk("force mem_addr", 32'(mem_addr), 32'h4);
        tick();
        dma_valid = 1'b0;
        mid();
        chk("after force stall", 32'(cpu_stall), 32'h0);
        chk("after force mem_addr", 32'(mem_addr), 32'h8);
        chk("after force rvalid", 32'(dma_rvalid), 32'h1);
        chk("after force rdata", dma_rdata, 32'hDEAD_BEEF);
        tick();
        idle();
        mid();
        chk("after force cpu_rdata", cpu_rdata, 32'h0);
        tick();

        // reset lands between a DMA read grant and its data return
        dma_valid = 1'b1; dma_addr = 32'h10;
        mid();
        chk("rstrd ready", 32'(dma_ready), 32'h1);
        rst_n = 1'b0;
        idle();
        tick();
        chk("rstrd rvalid in reset", 32'(dma_rvalid), 32'h0);
        rst_n = 1'b1;
        mid();
        chk("rstrd rvalid after", 32'(dma_rvalid), 32'h0);
        tick();

        // partial starvation cleared by reset: full MAXW denials needed again
        cpu_req = 1'b1; dma_valid = 1'b1; dma_addr = 32'h10;
        for (int k = 0; k < MAXW-1; k++) tick();
        mid();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            mid();
            if (dma_ready) break;
            cnt++;
            tick();
        end
        chk("denials after reset", 32'(cnt), 32'(MAXW));
        tick();
        idle();
        mid();
        tick();

`ifdef DMEM_ARB_RANGE_CHK_EN
        dma_valid = 1'b1; dma_addr = 32'h0000_0100;
        mid();
        chk("oow ready", 32'(dma_ready), 32'h1);
        chk("oow mem_en", 32'(mem_en), 32'h0);
        tick();
        idle();
        mid();
        chk("oow err", 32'(dma_err), 32'h1);
        chk("oow rvalid", 32'(dma_rvalid), 32'h0);
        tick();
        dma_valid = 1'b1; dma_addr = 32'h0000_0900;
        mid();
        chk("inw mem_en", 32'(mem_en), 32'h1);
        tick();
        idle();
        mid();
        chk("inw rvalid", 32'(dma_rvalid), 32'h1);
        chk("inw err", 32'(dma_err), 32'h0);
        chk("inw rdata", dma_rdata, 32'hA5A5_A5A5);
        tick();
`endif

        // random phase: fresh RAM and shadow
        clr_ram = 1'b1;
        tick();
        clr_ram = 1'b0;
        for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;
        streak = 0; p_dma_rd = 0; p_cpu_rd = 0; p_err = 0; last_rdy = 0; last_stall = 0;
        p_dma_data = 0; p_cpu_data = 0;

        for (int c = 0; c < 400; c++) begin
            bit          inw, acc, stl, cg, iss;
            logic [3:0]  e_we;
            logic [9:0]  e_ad;
            logic [31:0] e_wd;
            if (!(dma_valid && !last_rdy)) begin
                dma_valid = ($urandom_range(0, 9) < 6);
                dma_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                dma_addr  = (($urandom_range(0, 1) != 0) ? 32'h800 : 32'h0) |
                            (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                dma_wdata = $urandom();
            end
            if (!(cpu_req && last_stall)) begin
                cpu_req   = ($urandom_range(0, 1) != 0);
                cpu_we    = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
                cpu_addr  = ($urandom() & 32'hFFFF_F000) |
                            (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                cpu_wdata = $urandom();
            end
            mid();
            inw  = in_window(dma_addr);
            acc  = dma_valid && (!cpu_req || streak >= MAXW);
            stl  = cpu_req && dma_valid && (streak >= MAXW);
            cg   = cpu_req && !stl;
            iss  = acc && inw;
            e_we = cg ? cpu_we : (iss ? dma_we : 4'h0);
            e_ad = cg ? wd(cpu_addr) : wd(dma_addr);
            e_wd = cg ? cpu_wdata : dma_wdata;
            chk("rnd dma_ready", 32'(dma_ready), 32'(acc));
            chk("rnd cpu_stall", 32'(cpu_stall), 32'(stl));
            chk("rnd mem_en", 32'(mem_en), 32'(cg || iss));
            chk("rnd mem_we", 32'(mem_we), 32'(e_we));
            if (cg || iss) chk("rnd mem_addr", 32'(mem_addr), 32'(e_ad));
            if (e_we != 4'h0) chk("rnd mem_wdata", mem_wdata, e_wd);
            chk("rnd dma_rvalid", 32'(dma_rvalid), 32'(p_dma_rd));
            if (p_dma_rd) chk("rnd dma_rdata", dma_rdata, p_dma_data);
            if (p_cpu_rd) chk("rnd cpu_rdata", cpu_rdata, p_cpu_data);
            chk("rnd dma_err", 32'(dma_err), 32'(p_err));
            p_dma_rd   = iss && (dma_we == 4'h0);
            p_dma_data = shadow[wd(dma_addr)];
            p_cpu_rd   = cg && (cpu_we == 4'h0);
            p_cpu_data = shadow[wd(cpu_addr)];
            p_err      = acc && !inw;
            if (cg || iss)
                for (int b = 0; b < 4; b++)
                    if (e_we[b]) shadow[e_ad][8*b +: 8] = e_wd[8*b +: 8];
            streak     = (dma_valid && !acc) ? streak + 1 : 0;
            last_rdy   = acc;
            last_stall = stl;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port DATA_MEM block RAM (1-cycle read latency, byte write enables, word-addressed) between the pipelined core's MEM stage and a secondary DMA/debug master.
- The core gets fixed priority. A starvation counter forces a DMA grant after MAX_WAIT denied cycles, and the core is stalled for that cycle.
- Sits in the clk_core domain between processor_core, the DMA master and DATA_MEM.

Parameters:
- ADDR_W, 10, word-address width to DATA_MEM (byte address bits [ADDR_W+1:2]).
- MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA grant; legal range 1..15.
- WIN_BASE, 32'h0000_0800, DMA window base byte address (used only with the optional feature).
- WIN_SIZE, 32'h0000_0800, DMA window size in bytes (used only with the optional feature).

Ports:
- clk  in  1  core clock (clk_core)
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  MEM stage performs a load or store this cycle
- cpu_we  in  4  byte write enables (0 = read)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid the cycle after grant
- cpu_stall  out  1  core must hold its MEM stage this cycle
- dma_valid  in  1  DMA request
- dma_ready  out  1  DMA request accepted this cycle
- dma_we  in  4  byte write enables
- dma_addr  in  32  byte address
- dma_wdata  in  32  write data
- dma_rvalid  out  1  read data valid pulse
- dma_rdata  out  32  read data
- dma_err  out  1  one-cycle error pulse (optional feature only; tied 0 otherwise)
- mem_en  out  1  DATA_MEM enable
- mem_we  out  4  DATA_MEM byte write enables
- mem_addr  out  ADDR_W  DATA_MEM word address
- mem_wdata  out  32  DATA_MEM write data
- mem_rdata  in  32  DATA_MEM read data, 1 cycle after mem_en

Behaviour:
- Reset (rst_n low, asynchronous): state=ST_CPU, wait_cnt=0, rd_owner pipe cleared. Outputs: dma_ready=0, dma_rvalid=0, dma_err=0, cpu_stall=0, mem_en=0, mem_we=0.
- Grant decision is combinational from current state and requests. Memory port outputs are combinational muxes of the granted master.
- ST_CPU:
  - cpu_req=1 → grant CPU, cpu_stall=0, dma_ready=0.
  - cpu_req=0 and dma_valid=1 → grant DMA, dma_ready=1.
  - Neither request → mem_en=0.
- wait_cnt:
  - Increments on each cycle with dma_valid=1 and dma_ready=0.
  - Clears on dma_ready=1 or dma_valid=0.
  - Saturates at MAX_WAIT.
  - When wait_cnt reaches MAX_WAIT, next state is ST_FORCE.
- ST_FORCE:
  - Grant DMA unconditionally; dma_ready=1; cpu_stall=cpu_req.
  - Return to ST_CPU next cycle; wait_cnt cleared.
  - If dma_valid drops before ST_FORCE (master withdrew), return to ST_CPU with no grant and no stall.
- DMA handshake: request fields must stay stable while dma_valid=1 and dma_ready=0. Transfer completes on dma_valid & dma_ready.
- Read return (1-cycle rd_owner register):
  - DMA read granted at cycle N (dma_we==0) → dma_rvalid=1 and dma_rdata=mem_rdata at N+1.
  - Writes never produce dma_rvalid.
  - cpu_rdata = mem_rdata always; meaningful only at N+1 after a CPU grant at N.
- A stalled CPU request is re-presented next cycle and granted then. Its read data follows one cycle later.
- Back-to-back DMA grants are allowed each cycle; the pipeline is single-issue, one per cycle.
- Address mapping: mem_addr = granted_addr[ADDR_W+1:2]; the upper bits and [1:0] are ignored.
- Reset mid-read: the pending dma_rvalid is suppressed; no data is returned.

Optional Feature:
- Macro DMEM_ARB_RANGE_CHK_EN.
- Defined:
  - DMA requests with dma_addr outside [WIN_BASE, WIN_BASE+WIN_SIZE) are accepted (dma_ready=1) but not issued: mem_en=0 for that request.
  - dma_err pulses at N+1; dma_rvalid stays 0.
  - Rejected requests still clear wait_cnt.
- Undefined: no check is made; dma_err is constant 0.

Test Plan:
- Reset release, no requests → mem_en=0, cpu_stall=0, dma_ready=0, dma_rvalid=0 for 10 cycles.
- CPU-only store: cpu_we=4'hF, addr 0x10, data 0xDEADBEEF, then load addr 0x10 → mem_addr=4, cpu_rdata=0xDEADBEEF one cycle after the load grant.
- DMA-only read of 0x10 with cpu_req=0 → dma_ready same cycle, dma_rvalid=1 with dma_rdata=0xDEADBEEF next cycle.
- cpu_req held 1 and dma_valid held 1, MAX_WAIT=4 → DMA denied 4 cycles, 5th cycle dma_ready=1 and cpu_stall=1, 6th cycle CPU granted with no stall.
- Async reset asserted the cycle after a DMA read grant → dma_rvalid stays 0, state returns to ST_CPU, wait_cnt=0.
- With DMEM_ARB_RANGE_CHK_EN: DMA read at 0x0000_0100 → dma_ready=1, mem_en=0, dma_err=1 next cycle. DMA read at 0x0000_0900 → normal dma_rvalid.
